// File: rtl/mesi_tag_store_if.sv
// Command, MESI-block and response bundle around the MESI tag store.
// slave = the tag store; master = the trace driver that also plays the MESI block.
// One command in flight at a time, gated by req_ready.
interface mesi_tag_store_if #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 4
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        mesi_present_state;
  logic [3:0]        mesi_command;
  logic [1:0]        mesi_result_state;
  logic [1:0]        mesi_result_response;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [WAY_W-1:0]  rsp_way;
  logic [1:0]        rsp_state;
  logic [1:0]        rsp_snoop_response;
  logic              rsp_evict;
  logic              rsp_evict_dirty;

  modport slave (
    input  req_valid, req_cmd, req_addr, mesi_result_state, mesi_result_response,
    output req_ready, mesi_present_state, mesi_command,
           rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_snoop_response,
           rsp_evict, rsp_evict_dirty
  );

  modport master (
    output req_valid, req_cmd, req_addr, mesi_result_state, mesi_result_response,
    input  req_ready, mesi_present_state, mesi_command,
           rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_snoop_response,
           rsp_evict, rsp_evict_dirty
  );
endinterface

// File: rtl/mesi_tag_store.sv
// Set-associative tag/MESI-state array with true-LRU in front of a combinational MESI block.
// Latency: rsp_valid two cycles after acceptance (IDLE -> LOOKUP -> UPDATE), one command per 3 cycles.
// Backpressure: req_ready is high only in IDLE and never during reset.
module mesi_tag_store #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int SETS     = 16,
  parameter int WAYS     = 4
) (
  input logic            clk,
  input logic            rst,
  mesi_tag_store_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
  localparam logic [1:0] ST_M = 2'b00;
  localparam logic [1:0] ST_I = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} fsm_e;

  fsm_e              state_q, state_d;
  logic [3:0]        cmd_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;

  logic [TAG_W-1:0]  tag_arr_q [SETS][WAYS];
  logic [1:0]        st_arr_q  [SETS][WAYS];
  logic [WAY_W-1:0]  age_arr_q [SETS][WAYS];

  logic              rsp_hit_q, rsp_evict_q, rsp_dirty_q;
  logic [WAY_W-1:0]  rsp_way_q;
  logic [1:0]        rsp_state_q, rsp_resp_q;

  logic              accept, is_l1, is_snoop, is_clear;
  logic              hit, free_found;
  logic [WAY_W-1:0]  hit_way, victim, touch_age;
  logic              unused_offset;

  // Offset bits select a byte within the line and play no part in lookup.
  assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign is_l1         = (cmd_q <= 4'd2);
  assign is_snoop      = (cmd_q >= 4'd3) && (cmd_q <= 4'd6);
  assign is_clear      = (cmd_q == 4'd8);

  // Tag compare across the addressed set; a stale tag in state I never hits.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tag_arr_q[idx_q][w] == tag_q && st_arr_q[idx_q][w] != ST_I) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the least recently used way.
  always_comb begin
    free_found = 1'b0;
    victim     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!free_found && st_arr_q[idx_q][w] == ST_I) begin
        free_found = 1'b1;
        victim     = WAY_W'(w);
      end
    end
    if (!free_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_arr_q[idx_q][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  assign touch_age = age_arr_q[idx_q][rsp_way_q];

  // The MESI block sees the looked-up state only during LOOKUP; I elsewhere.
  assign bus.mesi_present_state = (state_q == LOOKUP && hit) ? st_arr_q[idx_q][hit_way] : ST_I;
  assign bus.mesi_command       = cmd_q;

  assign bus.rsp_valid          = (state_q == UPDATE) && !rst;
  assign bus.rsp_hit            = rsp_hit_q;
  assign bus.rsp_way            = rsp_way_q;
  assign bus.rsp_state          = rsp_state_q;
  assign bus.rsp_snoop_response = rsp_resp_q;
  assign bus.rsp_evict          = rsp_evict_q;
  assign bus.rsp_evict_dirty    = rsp_dirty_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one pass through LOOKUP and UPDATE per accepted command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the command and the index/tag split of its address on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
      idx_q <= '0;
      tag_q <= '0;
    end else if (accept) begin
      cmd_q <= bus.req_cmd;
      idx_q <= bus.req_addr[OFFSET_W +: IDX_W];
      tag_q <= bus.req_addr[ADDR_W-1 -: TAG_W];
    end
  end

  // Register lookup outcome and MESI result at the end of LOOKUP; held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_state_q <= '0;
      rsp_resp_q  <= '0;
      rsp_evict_q <= 1'b0;
      rsp_dirty_q <= 1'b0;
    end else if (state_q == LOOKUP) begin
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_state_q <= '0;
      rsp_resp_q  <= '0;
      rsp_evict_q <= 1'b0;
      rsp_dirty_q <= 1'b0;
      if (is_l1) begin
        rsp_hit_q   <= hit;
        rsp_way_q   <= hit ? hit_way : victim;
        rsp_state_q <= bus.mesi_result_state;
        rsp_resp_q  <= bus.mesi_result_response;
        rsp_evict_q <= !hit && (st_arr_q[idx_q][victim] != ST_I);
        rsp_dirty_q <= !hit && (st_arr_q[idx_q][victim] == ST_M);
      end else if (is_snoop) begin
        rsp_hit_q   <= hit;
        rsp_way_q   <= hit ? hit_way : '0;
        rsp_state_q <= bus.mesi_result_state;
        rsp_resp_q  <= bus.mesi_result_response;
      end
    end
  end

  // Array and LRU write-back in UPDATE; clear and reset both reinitialise every set.
  always_ff @(posedge clk) begin
    if (rst || (state_q == UPDATE && is_clear)) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          st_arr_q[s][w]  <= ST_I;
          age_arr_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (state_q == UPDATE) begin
      if (is_l1) begin
        tag_arr_q[idx_q][rsp_way_q] <= tag_q;
        st_arr_q[idx_q][rsp_way_q]  <= rsp_state_q;
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == rsp_way_q)
            age_arr_q[idx_q][w] <= '0;
          else if (age_arr_q[idx_q][w] < touch_age)
            age_arr_q[idx_q][w] <= age_arr_q[idx_q][w] + 1'b1;
        end
      end else if (is_snoop && rsp_hit_q) begin
        st_arr_q[idx_q][rsp_way_q] <= rsp_state_q;
      end
    end
  end
endmodule

// File: tb/tb_mesi_tag_store.sv
// Directed bench for mesi_tag_store: a reference cache model (tag/state arrays with an
// MRU-first recency list) predicts every response; a negedge compare process checks
// responses and held fields every cycle; literal expectations pin the test-plan values.
module tb_mesi_tag_store;
  localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
    logic [1:0] state;
    logic [1:0] resp;
    logic       ev;
    logic       dirty;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mesi_tag_store_if #(.ADDR_W(32), .WAYS(4)) bus ();

  mesi_tag_store #(.ADDR_W(32), .OFFSET_W(6), .SETS(16), .WAYS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [21:0] m_tag   [16][4];
  logic [1:0]  m_st    [16][4];
  int          m_order [16][4];   // m_order[s][0] is MRU, m_order[s][3] is LRU

  exp_t exp_q[$];
  exp_t cap;                      // last response actually seen from the DUT
  logic [1:0] lookup_present;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w]   = '0;
        m_st[s][w]    = I;
        m_order[s][w] = w;
      end
  endtask

  task automatic model_touch(input int s, input int w);
    int p;
    p = 0;
    for (int k = 0; k < 4; k++) if (m_order[s][k] == w) p = k;
    for (int k = p; k > 0; k--) m_order[s][k] = m_order[s][k-1];
    m_order[s][0] = w;
  endtask

  task automatic model_apply(input logic [3:0] cmd, input logic [31:0] addr,
                             input logic [1:0] rs, input logic [1:0] rr,
                             output exp_t e, output logic [1:0] present);
    int s, hw, v;
    logic [21:0] t;
    s  = int'(addr[9:6]);
    t  = addr[31:10];
    hw = -1;
    for (int w = 0; w < 4; w++) if (m_tag[s][w] == t && m_st[s][w] != I) hw = w;
    e = '0;
    present = (hw >= 0) ? m_st[s][hw] : I;
    if (cmd <= 4'd2) begin
      if (hw >= 0) v = hw;
      else begin
        v = -1;
        for (int w = 0; w < 4; w++) if (v < 0 && m_st[s][w] == I) v = w;
        if (v < 0) v = m_order[s][3];
        e.ev    = (m_st[s][v] != I);
        e.dirty = (m_st[s][v] == M);
      end
      e.hit = (hw >= 0); e.way = v[1:0]; e.state = rs; e.resp = rr;
      m_tag[s][v] = t;
      m_st[s][v]  = rs;
      model_touch(s, v);
    end else if (cmd >= 4'd3 && cmd <= 4'd6) begin
      e.hit = (hw >= 0); e.way = (hw >= 0) ? hw[1:0] : 2'd0; e.state = rs; e.resp = rr;
      if (hw >= 0) m_st[s][hw] = rs;
    end else if (cmd == 4'd8) begin
      model_reset();
    end
  endtask

  // Compare process: responses against the model, and held fields on every other cycle.
  logic prev_rst = 1'b0;
  logic started  = 1'b0;
  exp_t last     = '0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      last    = '0;
      started = 1'b1;
    end
    prev_rst = rst;
    if (started) begin
      if (bus.rsp_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cap = '{bus.rsp_hit, bus.rsp_way, bus.rsp_state, bus.rsp_snoop_response,
                bus.rsp_evict, bus.rsp_evict_dirty};
        chk("rsp_hit",         bus.rsp_hit,            e.hit);
        chk("rsp_way",         bus.rsp_way,            e.way);
        chk("rsp_state",       bus.rsp_state,          e.state);
        chk("rsp_snoop_resp",  bus.rsp_snoop_response, e.resp);
        chk("rsp_evict",       bus.rsp_evict,          e.ev);
        chk("rsp_evict_dirty", bus.rsp_evict_dirty,    e.dirty);
        last = e;
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 1'b0);
        chk("held_fields", {bus.rsp_hit, bus.rsp_way, bus.rsp_state, bus.rsp_snoop_response,
                            bus.rsp_evict, bus.rsp_evict_dirty}, last);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", bus.req_ready, 1'b1);
  endtask

  task automatic do_cmd(input logic [3:0] cmd, input logic [31:0] addr,
                        input logic [1:0] rs, input logic [1:0] rr);
    exp_t e;
    logic [1:0] pres;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.mesi_result_state    = rs;
    bus.mesi_result_response = rr;
    model_apply(cmd, addr, rs, rr, e, pres);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lookup_present = bus.mesi_present_state;
    chk("mesi_present_state", bus.mesi_present_state, pres);
    chk("mesi_command",       bus.mesi_command,       cmd);
    exp_q.push_back(e);
    @(posedge clk);
    @(posedge clk); #1;
    chk("rsp_pending", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.mesi_result_state    = I;
    bus.mesi_result_response = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready",  bus.req_ready,          1'b0);
    chk("reset_rsp_valid",  bus.rsp_valid,          1'b0);
    chk("reset_present",    bus.mesi_present_state, I);
    chk("reset_command",    bus.mesi_command,       4'd0);
    chk("reset_rsp_way",    bus.rsp_way,            2'd0);
    chk("reset_rsp_evict",  bus.rsp_evict,          1'b0);
    rst = 1'b0;

    // Fill set 1, then evict the LRU way 0 (clean)
    do_cmd(4'd0, 32'h0000_0040, E, 2'd0); chk("fill0_way", cap.way, 2'd0); chk("fill0_hit", cap.hit, 1'b0);
    do_cmd(4'd0, 32'h0000_0440, E, 2'd0); chk("fill1_way", cap.way, 2'd1);
    do_cmd(4'd0, 32'h0000_0840, E, 2'd0); chk("fill2_way", cap.way, 2'd2);
    do_cmd(4'd0, 32'h0000_0C40, E, 2'd0); chk("fill3_way", cap.way, 2'd3); chk("fill3_evict", cap.ev, 1'b0);
    do_cmd(4'd0, 32'h0000_1040, E, 2'd0);
    chk("evict0_way", cap.way, 2'd0); chk("evict0_evict", cap.ev, 1'b1); chk("evict0_dirty", cap.dirty, 1'b0);

    // Write hit E->M, then push way 1 out dirty
    do_cmd(4'd1, 32'h0000_0440, M, 2'd0);
    chk("wr_present", lookup_present, E); chk("wr_hit", cap.hit, 1'b1); chk("wr_state", cap.state, M);
    do_cmd(4'd0, 32'h0000_1440, E, 2'd0);
    do_cmd(4'd0, 32'h0000_1840, E, 2'd0);
    do_cmd(4'd0, 32'h0000_1C40, E, 2'd0);
    do_cmd(4'd0, 32'h0000_2040, E, 2'd0);
    chk("dirty_way", cap.way, 2'd1); chk("dirty_evict", cap.dirty, 1'b1);

    // Snoop to an absent line changes nothing
    do_cmd(4'd4, 32'h0000_2080, I, 2'd0);
    chk("snmiss_present", lookup_present, I); chk("snmiss_hit", cap.hit, 1'b0); chk("snmiss_resp", cap.resp, 2'd0);
    do_cmd(4'd0, 32'h0000_2080, E, 2'd0); chk("after_snoop_hit", cap.hit, 1'b0); chk("after_snoop_way", cap.way, 2'd0);
    do_cmd(4'd0, 32'h0000_2040, E, 2'd0); chk("reread_hit", cap.hit, 1'b1); chk("reread_way", cap.way, 2'd1);

    // Invalidate way 2 of set 1 while way 3 is LRU; the next miss must refill way 2
    do_cmd(4'd0, 32'h0000_1440, E, 2'd0); chk("touch2_way", cap.way, 2'd2);
    do_cmd(4'd3, 32'h0000_1440, I, 2'd1);
    chk("inv_hit", cap.hit, 1'b1); chk("inv_way", cap.way, 2'd2); chk("inv_state", cap.state, I);
    do_cmd(4'd9, 32'h0000_1840, S, 2'd2); chk("print_hit", cap.hit, 1'b0); chk("print_state", cap.state, 2'd0);
    do_cmd(4'd7, 32'h0000_1840, S, 2'd2); chk("undef_resp", cap.resp, 2'd0);
    do_cmd(4'd4, 32'h0000_1840, S, 2'd1); chk("snhit_way", cap.way, 2'd3); chk("snhit_present", lookup_present, E);
    do_cmd(4'd0, 32'h0000_2440, E, 2'd0);
    chk("refill_way", cap.way, 2'd2); chk("refill_evict", cap.ev, 1'b0);

    // Clear, then every former resident misses and refills ways 0..3 in order
    do_cmd(4'd8, 32'h0000_0000, M, 2'd2); chk("clear_hit", cap.hit, 1'b0); chk("clear_evict", cap.ev, 1'b0);
    do_cmd(4'd0, 32'h0000_1C40, E, 2'd0); chk("postclr0_hit", cap.hit, 1'b0); chk("postclr0_way", cap.way, 2'd0);
    do_cmd(4'd0, 32'h0000_2040, E, 2'd0); chk("postclr1_hit", cap.hit, 1'b0); chk("postclr1_way", cap.way, 2'd1);
    do_cmd(4'd0, 32'h0000_2440, E, 2'd0); chk("postclr2_hit", cap.hit, 1'b0); chk("postclr2_way", cap.way, 2'd2);
    do_cmd(4'd0, 32'h0000_1840, E, 2'd0); chk("postclr3_hit", cap.hit, 1'b0); chk("postclr3_way", cap.way, 2'd3);

    // Reset during LOOKUP aborts the command
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_cmd   = 4'd0;
    bus.req_addr  = 32'h0000_1C40;
    bus.mesi_result_state    = S;
    bus.mesi_result_response = 2'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_ready", bus.req_ready, 1'b1);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    chk("abort_no_rsp", n, 0);
    do_cmd(4'd0, 32'h0000_1C40, E, 2'd0); chk("abort_reread_hit", cap.hit, 1'b0); chk("abort_reread_way", cap.way, 2'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mesi_tag_store.md
Name: mesi_tag_store

Overview:
- Set-associative tag and MESI-state array that sits directly upstream of the combinational MESI next-state block.
- For each trace command it looks up the address and presents the line's current state plus the command to the MESI block.
- It captures the returned next state and snoop response, then writes the state back and maintains true-LRU replacement and eviction reporting.
- It turns the stateless MESI transition logic into a stateful cache model.

Parameters:
- ADDR_W, 32, address width in bits.
- OFFSET_W, 6, line-offset bits (64-byte lines).
- SETS, 16, number of sets (power of two); IDX_W = log2(SETS); TAG_W = ADDR_W-OFFSET_W-IDX_W.
- WAYS, 4, associativity (power of two); WAY_W = log2(WAYS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  command present.
- req_ready  out  1  store can accept a command.
- req_cmd  in  4  0 L1_read, 1 L1_write, 2 L1_inst_read, 3 snoop_invalidate, 4 snoop_read, 5 snoop_write, 6 snoop_readRFO, 8 clear, 9 print.
- req_addr  in  ADDR_W  byte address.
- mesi_present_state  out  2  to MESI block; encoding M=00, E=01, S=10, I=11.
- mesi_command  out  4  to MESI block; latched req_cmd.
- mesi_result_state  in  2  next state from MESI block (combinational).
- mesi_result_response  in  2  noHIT=00, HIT=01, HITM=10.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_hit  out  1  tag matched a non-I line.
- rsp_way  out  WAY_W  way hit or allocated.
- rsp_state  out  2  state written to the line.
- rsp_snoop_response  out  2  captured mesi_result_response.
- rsp_evict  out  1  allocation displaced a non-I line.
- rsp_evict_dirty  out  1  displaced line was M.

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high. It is sampled only on the rising clk edge.
- Reset effects:
  - All line states go to I.
  - Per-set LRU age of way i is set to i; age 0 is MRU and age WAYS-1 is LRU.
  - FSM goes to IDLE.
  - All rsp_* outputs go to 0.
  - mesi_present_state goes to I and mesi_command to 0.
  - req_ready is 0 while rst is high.
- FSM: IDLE -> LOOKUP -> UPDATE -> IDLE. req_ready=1 only in IDLE.
- A command is accepted on the edge where req_valid & req_ready are both high; cmd and addr are latched at that edge.
- rsp_valid pulses in the UPDATE cycle, two cycles after acceptance. Maximum throughput is one command per 3 cycles.
- LOOKUP, general:
  - Index = addr[OFFSET_W +: IDX_W]; tag = upper TAG_W bits.
  - Hit = some way has a matching tag and state != I; at most one such way exists.
  - Hit: mesi_present_state = stored state.
  - Miss: mesi_present_state = I.
  - mesi_command = latched cmd.
  - mesi_result_state and mesi_result_response are registered at the end of LOOKUP.
- LOOKUP, victim selection on an L1 miss (cmd 0-2):
  - Victim = lowest-index way in state I; if none, the way with age WAYS-1.
  - rsp_evict = victim state != I; rsp_evict_dirty = victim state == M.
- UPDATE:
  - Hit: write the result state to the hit way.
  - L1 miss: write the tag and result state to the victim way.
  - Snoop miss (cmd 3-6): no array write; rsp_way=0.
  - A result state of I keeps the stale tag; the line counts as invalid.
- LRU is updated only on L1 commands (hit or allocate). The touched way gets age 0. Every way whose age was below the touched way's old age increments by 1. Snoops never change LRU.
- clear (8): in UPDATE, all lines in all sets go to I and LRU reinitialises as at reset. MESI results are ignored. rsp_hit=0, rsp_evict=0.
- print (9) and undefined codes (7, 10-15): no array or LRU change. rsp_valid pulses with rsp_hit=0 and all other rsp fields 0.
- rsp_* fields are held stable from UPDATE until the next UPDATE, except rsp_valid.
- rst during LOOKUP or UPDATE aborts the command: no array or LRU write, no rsp_valid.

Test Plan:
- Fill set 1: L1_read to 0x0000_0040, 0x0000_0440, 0x0000_0840, 0x0000_0C40, with the bench returning E each time -> rsp_way 0,1,2,3, rsp_hit=0, rsp_evict=0. A 5th read to 0x0000_1040 -> rsp_way=0, rsp_evict=1, rsp_evict_dirty=0.
- L1_write to resident 0x0000_0440, bench returns M -> mesi_present_state=E in LOOKUP, rsp_hit=1, rsp_state=M. After three more new tags in set 1, the eviction of way 1 reports rsp_evict_dirty=1.
- snoop_read to absent 0x0000_2080 -> mesi_present_state=I, rsp_hit=0, rsp_snoop_response equals the bench value (00). A following lookup shows the array and LRU unchanged.
- snoop_invalidate hit on way 2, bench returns I -> rsp_state=I. Next L1_read miss in that set allocates way 2 even though way 3 is LRU.
- clear, then L1_read to each previously resident address -> all rsp_hit=0, with allocation in ways 0,1,2,3 in order.
- Assert rst in the LOOKUP cycle of an L1_read -> no rsp_valid, req_ready=1 one cycle after rst drops, and re-reading the address misses.
